// File: rtl/rotate_undo_seq.sv
// Sequential inverse of the barrel rotator: undoes a left/right rotation by
// stepping the captured word one bit position per clock in the opposite direction.
module rotate_undo_seq #(
   parameter int BIT = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [BIT-1:0]          i_data,
   input  logic                    i_sel_left,
   input  logic [$clog2(BIT)-1:0]  i_shifter,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [BIT-1:0]          o_data,
   output logic                    o_busy
);

   localparam int CW = $clog2(BIT);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t          state_q;
   logic [BIT-1:0]  data_q;
   logic [BIT-1:0]  data_d;
   logic            dir_q;
   logic [CW-1:0]   cnt_q;

   // One-position step opposite to the original rotation direction.
   always_comb begin
      data_d = data_q;
      if (dir_q) begin
         data_d = {data_q[0], data_q[BIT-1:1]};
      end else begin
         data_d = {data_q[BIT-2:0], data_q[BIT-1]};
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         data_q  <= '0;
         dir_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_valid) begin
                  data_q  <= i_data;
                  dir_q   <= i_sel_left;
                  cnt_q   <= i_shifter;
                  state_q <= (i_shifter != '0) ? SHIFT : DONE;
               end
            end
            SHIFT: begin
               data_q <= data_d;
               cnt_q  <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (i_ready) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_ready = (state_q == IDLE);
   assign o_busy  = (state_q != IDLE);
   assign o_valid = (state_q == DONE);
   assign o_data  = data_q;

endmodule
